vic_vector: RTL
===============

// Module: vic_vector
// PURPOSE
//  Downstream stage of the VICtor interrupt controller. Takes the one-line
//  request and the 5-bit interrupt index from the priority stage, and looks
//  up the handler address in a programmable 31-entry vector table.
//  Runs the request/ack/end-of-interrupt handshake with the CPU.
//  Drives the in-service level back into the priority stage's i_IRQ input.
// PARAMETERS
//  NUM_IRQ        31     number of interrupt sources / vector table entries
//  VEC_W          32     width of a handler address
//  ACK_TIMEOUT    255    cycles to wait for i_cpu_ack in REQ; 0 = never time out
//  DEFAULT_VECTOR 32'h0  vector returned for an entry never written (spurious)
// PORTS
//  i_clk        in   1      clock, rising edge
//  i_rst        in   1      reset, asynchronous, active-high
//  i_en         in   1      global enable; same signal as the priority stage's i_en
//  i_irq        in   1      request from the priority stage (its o_IRQ)
//  i_irq_addr   in   5      index of the requesting source (its o_irq_addr)
//  i_wr_en      in   1      vector table write strobe
//  i_wr_addr    in   5      vector table write index (0..NUM_IRQ-1)
//  i_wr_data    in   VEC_W  handler address to store
//  i_cpu_ack    in   1      CPU has taken the vector
//  i_cpu_eoi    in   1      CPU finished the handler (end of interrupt)
//  o_cpu_irq    out  1      interrupt request to the CPU
//  o_vector     out  VEC_W  handler address for the current interrupt
//  o_cur_id     out  5      index being served
//  o_in_service out  1      to the priority stage's i_IRQ; high while busy
//  o_timeout    out  1      sticky: an ack timeout occurred; cleared only by i_rst
// BEHAVIOUR
//  - Reset (async): all outputs 0, state IDLE, timer 0, all table valid bits 0.
//    Table data is don't-care after reset. Reset aborts any state immediately.
//  - Sampling of i_irq:
//    - i_irq and i_irq_addr are sampled on rising i_clk.
//    - The upstream stage holds i_irq across at least one rising edge.
//    - A request is accepted only in IDLE with i_en=1 and i_irq_addr < NUM_IRQ.
//      Out-of-range indices are ignored.
//  - Table write: synchronous, any state. entry[i_wr_addr] <= i_wr_data; valid <= 1.
//    Writes with i_wr_addr >= NUM_IRQ are dropped.
//  - Lookup is read-before-write: if a write and an accept hit the same index in
//    one cycle, o_vector takes the old entry (DEFAULT_VECTOR if it was invalid).
//  - FSM states: IDLE, REQ, SERVICE, RELEASE.
//    - IDLE -> REQ on accept. That same edge registers:
//      - o_vector = valid ? entry : DEFAULT_VECTOR
//      - o_cur_id = i_irq_addr
//      - o_cpu_irq = 1, o_in_service = 1, timer = 0
//      Latency from the i_irq sample edge to o_cpu_irq high is 1 cycle.
//    - REQ, i_cpu_ack=1 -> SERVICE. o_cpu_irq = 0; o_in_service stays 1.
//    - REQ, no ack -> timer increments each cycle.
//      - When timer == ACK_TIMEOUT-1 (ACK_TIMEOUT != 0): go to RELEASE, o_timeout = 1.
//    - REQ, i_en=0 -> RELEASE (abort), o_timeout unchanged.
//      If ack and i_en=0 arrive together, the ack wins: go to SERVICE.
//    - SERVICE, i_cpu_eoi=1 -> RELEASE. i_en is ignored in SERVICE.
//      i_cpu_ack in SERVICE is ignored.
//    - RELEASE: exactly one cycle. o_in_service = 0, o_cpu_irq = 0, then -> IDLE.
//      This falling edge of o_in_service is what the priority stage uses to clear
//      the served source, so RELEASE is never skipped.
//    - IDLE does not accept in the RELEASE cycle.
//      Earliest re-accept is the edge after entering IDLE.
//  - o_vector and o_cur_id hold their last values in IDLE until the next accept.
//  - i_cpu_eoi outside SERVICE and i_cpu_ack outside REQ are ignored.
//  - Timer is 8 bits wide and saturates; it never wraps.
//    ACK_TIMEOUT is required to be <= 255.
// TESTING
//  1. Write entry 5 = 32'h0000_1040. Pulse i_irq with addr 5.
//     -> o_cpu_irq=1 and o_vector=32'h0000_1040, o_cur_id=5, one cycle later.
//     -> After ack then eoi: o_in_service low for exactly 1 cycle, then IDLE.
//  2. Request on never-written entry 12 -> o_vector = DEFAULT_VECTOR (0), normal handshake.
//  3. ACK_TIMEOUT=4, request with no ack -> o_cpu_irq high for 4 cycles.
//     -> Then RELEASE, o_timeout=1 and it stays 1 through later good requests.
//  4. In one cycle, write entry 3 = 32'hAAAA and accept a request on addr 3.
//     Old value was 32'h5555 -> o_vector=32'h5555; the next request on 3 gives 32'hAAAA.
//  5. Assert i_irq (addr 7) during SERVICE of addr 2 -> ignored, o_cur_id stays 2.
//     -> Addr 7 is accepted only if i_irq is still held on the edge after IDLE re-entry.
//  6. Assert i_rst in SERVICE -> in the same cycle (async): o_in_service=0, o_cpu_irq=0.
//     -> After reset, a request on a previously written entry returns DEFAULT_VECTOR.

Source files
------------

// File: rtl/vic_vector.sv
// ----------------------------------------------------------------------------
// vic_vector
//
// Downstream stage of the VICtor interrupt controller. It takes the request
// and the 5-bit source index from the priority stage. It looks up the handler
// address in a programmable vector table and runs the request / ack /
// end-of-interrupt handshake with the CPU. It also drives the in-service level
// back to the priority stage.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_en         global enable (shared with the priority stage)
//   i_irq        request from the priority stage
//   i_irq_addr   index of the requesting source
//   i_wr_en      vector table write strobe
//   i_wr_addr    vector table write index
//   i_wr_data    handler address to store
//   i_cpu_ack    CPU has taken the vector
//   i_cpu_eoi    CPU has finished the handler
//   o_cpu_irq    interrupt request to the CPU
//   o_vector     handler address of the current interrupt
//   o_cur_id     index being served
//   o_in_service high while an interrupt is in flight (to priority i_IRQ)
//   o_timeout    sticky ack-timeout flag, cleared only by reset
// ----------------------------------------------------------------------------
module vic_vector #(
   parameter int               NUM_IRQ        = 31,
   parameter int               VEC_W          = 32,
   parameter int               ACK_TIMEOUT    = 255,
   parameter logic [VEC_W-1:0] DEFAULT_VECTOR = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_irq,
   input  logic [4:0]       i_irq_addr,
   input  logic             i_wr_en,
   input  logic [4:0]       i_wr_addr,
   input  logic [VEC_W-1:0] i_wr_data,
   input  logic             i_cpu_ack,
   input  logic             i_cpu_eoi,
   output logic             o_cpu_irq,
   output logic [VEC_W-1:0] o_vector,
   output logic [4:0]       o_cur_id,
   output logic             o_in_service,
   output logic             o_timeout
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_SERVICE,
      ST_RELEASE
   } state_t;

   // Last timer value before the ack timeout fires.
   localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 1);

   state_t             state_q, state_d;
   logic [7:0]         timer_q, timer_d;
   logic               cpu_irq_q, cpu_irq_d;
   logic               in_service_q, in_service_d;
   logic [VEC_W-1:0]   vector_q, vector_d;
   logic [4:0]         cur_id_q, cur_id_d;
   logic               timeout_q, timeout_d;

   // Vector table: the data array has no reset. Only the valid bits are reset.
   logic [VEC_W-1:0]   mem_q [NUM_IRQ];
   logic [NUM_IRQ-1:0] valid_q;
   logic [NUM_IRQ-1:0] wr_sel;

   logic               wr_hit;
   logic               irq_in_range;
   logic [4:0]         rd_idx;
   logic [VEC_W-1:0]   lookup_vec;
   logic               accept;

   assign wr_hit       = i_wr_en && (32'(i_wr_addr) < 32'(NUM_IRQ));
   assign irq_in_range = (32'(i_irq_addr) < 32'(NUM_IRQ));
   assign accept       = (state_q == ST_IDLE) && i_en && i_irq && irq_in_range;

   // Keep the read index inside the table even when the request is ignored.
   assign rd_idx     = irq_in_range ? i_irq_addr : 5'd0;
   // The lookup reads the current contents of the table. A write in the same
   // cycle has not landed yet, so the lookup sees the old entry.
   assign lookup_vec = valid_q[rd_idx] ? mem_q[rd_idx] : DEFAULT_VECTOR;

   // ------------------------------------------------------------------------
   // Vector table
   // ------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_wr_sel
         assign wr_sel[gi] = wr_hit && (i_wr_addr == 5'(gi));
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (wr_hit) begin
         mem_q[i_wr_addr] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_q | wr_sel;
      end
   end

   // ------------------------------------------------------------------------
   // Handshake FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         cpu_irq_q    <= 1'b0;
         in_service_q <= 1'b0;
         vector_q     <= '0;
         cur_id_q     <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         cpu_irq_q    <= cpu_irq_d;
         in_service_q <= in_service_d;
         vector_q     <= vector_d;
         cur_id_q     <= cur_id_d;
         timeout_q    <= timeout_d;
      end
   end

   // ------------------------------------------------------------------------
   // Handshake FSM: next state and registered outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      cpu_irq_d    = cpu_irq_q;
      in_service_d = in_service_q;
      vector_d     = vector_q;
      cur_id_d     = cur_id_q;
      timeout_d    = timeout_q;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d      = ST_REQ;
               vector_d     = lookup_vec;
               cur_id_d     = i_irq_addr;
               cpu_irq_d    = 1'b1;
               in_service_d = 1'b1;
               timer_d      = '0;
            end
         end

         ST_REQ: begin
            // The ack has priority over an abort or a timeout in the same cycle.
            if (i_cpu_ack) begin
               state_d   = ST_SERVICE;
               cpu_irq_d = 1'b0;
            end else if (!i_en) begin
               state_d      = ST_RELEASE;
               cpu_irq_d    = 1'b0;
               in_service_d = 1'b0;
            end else if ((ACK_TIMEOUT != 0) && (timer_q == TIMER_LAST)) begin
               state_d      = ST_RELEASE;
               cpu_irq_d    = 1'b0;
               in_service_d = 1'b0;
               timeout_d    = 1'b1;
            end else if (timer_q != 8'hFF) begin
               timer_d = timer_q + 8'd1;
            end
         end

         ST_SERVICE: begin
            if (i_cpu_eoi) begin
               state_d      = ST_RELEASE;
               in_service_d = 1'b0;
            end
         end

         ST_RELEASE: begin
            // Always one cycle with o_in_service low. The priority stage clears
            // the served source on this falling edge.
            state_d      = ST_IDLE;
            cpu_irq_d    = 1'b0;
            in_service_d = 1'b0;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign o_cpu_irq    = cpu_irq_q;
   assign o_vector     = vector_q;
   assign o_cur_id     = cur_id_q;
   assign o_in_service = in_service_q;
   assign o_timeout    = timeout_q;

endmodule
